// File: rtl/e203_longp_pkg.sv
// ---------------------------------------------------------------------------
// e203_longp_pkg
//   Shared types and constants for the long-pipe retire scheduler.
//   longp_ent_t is the payload held for one long-pipe result while it waits
//   for its turn at the OITF head. The field widths are fixed here; the
//   scheduler's XLEN/ITAG_W parameters must match LONGP_XLEN/LONGP_ITAG_W.
// ---------------------------------------------------------------------------
package e203_longp_pkg;

    localparam int LONGP_XLEN   = 32;
    localparam int LONGP_ITAG_W = 1;

    // Source slots. The lower index wins if two entries ever match the head.
    localparam int LONGP_SRC_LSU  = 0;
    localparam int LONGP_SRC_NICE = 1;
    localparam int LONGP_SRC_NUM  = 2;

    typedef struct packed {
        logic [LONGP_XLEN-1:0]   wdat;
        logic [LONGP_ITAG_W-1:0] itag;
        logic                    err;
        logic                    buserr;
        logic [LONGP_XLEN-1:0]   badaddr;
        logic                    ld;
        logic                    st;
    } longp_ent_t;

    localparam int LONGP_ENT_W = $bits(longp_ent_t);

endpackage

// File: rtl/e203_longp_ret_buf.sv
// ---------------------------------------------------------------------------
// e203_longp_ret_buf
//   One-entry holding buffer for a long-pipe result.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (drops any held entry)
//   i_valid  in   upstream result valid
//   i_ready  out  accepted when empty, or when the held entry retires now
//   i_data   in   packed entry payload
//   ret      in   held entry leaves this cycle
//   full     out  an entry is held
//   o_data   out  held entry payload
// ---------------------------------------------------------------------------
module e203_longp_ret_buf
    import e203_longp_pkg::*;
#(
    parameter int W = LONGP_ENT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [W-1:0] i_data,
    input  logic         ret,
    output logic         full,
    output logic [W-1:0] o_data
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]   state_reg;
    logic [0:0]   state_next;
    logic [W-1:0] data_reg;
    logic [W-1:0] data_next;
    logic         accept;

    // A retiring entry frees the slot in the same cycle, so back-to-back
    // results stream without a bubble.
    assign i_ready = (state_reg == ST_EMPTY) | ret;
    assign accept  = i_valid & i_ready;

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                    data_next  = i_data;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    data_next = i_data;
                end else if (ret) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
        end
    end

    assign full   = (state_reg == ST_FULL);
    assign o_data = data_reg;

endmodule

// File: rtl/e203_exu_longp_ret_sched.sv
// ---------------------------------------------------------------------------
// e203_exu_longp_ret_sched
//   Retire scheduler for long-pipe (LSU, NICE) results. Each source has a
//   one-entry buffer; only the entry whose itag equals the OITF head pointer
//   may retire, steered either to regfile writeback or to the commit
//   exception port. A watchdog flags an OITF head that never returns.
//
//   clk, rst                      clock / synchronous active-high reset
//   lsu_i_*                       LSU result handshake and payload
//   nice_i_*                      NICE result handshake and payload
//   oitf_empty, oitf_ret_*        OITF head information
//   oitf_ret_ena                  pop OITF head (one pulse per retire)
//   wbck_o_*                      regfile writeback handshake and payload
//   excp_o_*                      commit exception handshake and payload
//   stall_timeout                 watchdog saturated (level)
// ---------------------------------------------------------------------------
module e203_exu_longp_ret_sched
    import e203_longp_pkg::*;
#(
    parameter int XLEN   = LONGP_XLEN,
    parameter int ITAG_W = LONGP_ITAG_W,
    parameter int WDG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              lsu_i_valid,
    output logic              lsu_i_ready,
    input  logic [XLEN-1:0]   lsu_i_wdat,
    input  logic [ITAG_W-1:0] lsu_i_itag,
    input  logic              lsu_i_err,
    input  logic              lsu_i_buserr,
    input  logic [XLEN-1:0]   lsu_i_badaddr,
    input  logic              lsu_i_ld,
    input  logic              lsu_i_st,

    input  logic              nice_i_valid,
    output logic              nice_i_ready,
    input  logic [XLEN-1:0]   nice_i_wdat,
    input  logic [ITAG_W-1:0] nice_i_itag,
    input  logic              nice_i_err,

    input  logic              oitf_empty,
    input  logic [ITAG_W-1:0] oitf_ret_ptr,
    input  logic [4:0]        oitf_ret_rdidx,
    input  logic              oitf_ret_rdwen,
    input  logic              oitf_ret_rdfpu,
    input  logic [XLEN-1:0]   oitf_ret_pc,
    output logic              oitf_ret_ena,

    output logic              wbck_o_valid,
    input  logic              wbck_o_ready,
    output logic [XLEN-1:0]   wbck_o_wdat,
    output logic [4:0]        wbck_o_rdidx,
    output logic              wbck_o_rdfpu,

    output logic              excp_o_valid,
    input  logic              excp_o_ready,
    output logic [XLEN-1:0]   excp_o_pc,
    output logic [XLEN-1:0]   excp_o_badaddr,
    output logic              excp_o_insterr,
    output logic              excp_o_buserr,
    output logic              excp_o_ld,
    output logic              excp_o_st,

    output logic              stall_timeout
);

    localparam logic [WDG_W-1:0] WDG_MAX = {WDG_W{1'b1}};

    longp_ent_t                 src_ent [LONGP_SRC_NUM];
    longp_ent_t                 buf_ent [LONGP_SRC_NUM];
    logic [LONGP_SRC_NUM-1:0]   src_valid;
    logic [LONGP_SRC_NUM-1:0]   src_ready;
    logic [LONGP_SRC_NUM-1:0]   src_full;
    logic [LONGP_SRC_NUM-1:0]   src_match;
    logic [LONGP_SRC_NUM-1:0]   src_ret;

    logic                       sel_lsu;
    logic                       sel_nice;
    logic                       any_sel;
    longp_ent_t                 sel_ent;
    logic                       retire;

    logic [WDG_W-1:0]           wdg_cnt_reg;
    logic [WDG_W-1:0]           wdg_cnt_next;

    // NICE carries no address or bus fault information; those fields are 0.
    assign src_ent[LONGP_SRC_LSU] = '{
        wdat:    lsu_i_wdat,
        itag:    lsu_i_itag,
        err:     lsu_i_err,
        buserr:  lsu_i_buserr,
        badaddr: lsu_i_badaddr,
        ld:      lsu_i_ld,
        st:      lsu_i_st
    };
    assign src_ent[LONGP_SRC_NICE] = '{
        wdat:    nice_i_wdat,
        itag:    nice_i_itag,
        err:     nice_i_err,
        buserr:  1'b0,
        badaddr: '0,
        ld:      1'b0,
        st:      1'b0
    };

    assign src_valid[LONGP_SRC_LSU]  = lsu_i_valid;
    assign src_valid[LONGP_SRC_NICE] = nice_i_valid;
    assign lsu_i_ready  = src_ready[LONGP_SRC_LSU];
    assign nice_i_ready = src_ready[LONGP_SRC_NICE];

    generate
        for (genvar gi = 0; gi < LONGP_SRC_NUM; gi++) begin : g_src
            logic [LONGP_ENT_W-1:0] buf_q;

            e203_longp_ret_buf #(
                .W (LONGP_ENT_W)
            ) u_buf (
                .clk     (clk),
                .rst     (rst),
                .i_valid (src_valid[gi]),
                .i_ready (src_ready[gi]),
                .i_data  (src_ent[gi]),
                .ret     (src_ret[gi]),
                .full    (src_full[gi]),
                .o_data  (buf_q)
            );

            assign buf_ent[gi] = longp_ent_t'(buf_q);

            // Entries only ever leave at the OITF head; a non-matching tag
            // simply waits. Nothing is offered while reset is asserted so a
            // reset never produces a retire pulse.
            assign src_match[gi] = src_full[gi] & ~oitf_empty & ~rst &
                                   (buf_ent[gi].itag == oitf_ret_ptr);
        end
    endgenerate

    // Two entries matching the head is illegal; LSU takes priority and NICE
    // keeps its entry.
    assign sel_lsu  = src_match[LONGP_SRC_LSU];
    assign sel_nice = src_match[LONGP_SRC_NICE] & ~src_match[LONGP_SRC_LSU];
    assign any_sel  = sel_lsu | sel_nice;
    assign sel_ent  = sel_lsu ? buf_ent[LONGP_SRC_LSU] : buf_ent[LONGP_SRC_NICE];

    // Faults go to the exception port, register writers to writeback, and
    // instructions with neither retire as soon as they are selected.
    always_comb begin
        retire = 1'b0;
        if (any_sel) begin
            if (sel_ent.err) begin
                retire = excp_o_ready;
            end else if (oitf_ret_rdwen) begin
                retire = wbck_o_ready;
            end else begin
                retire = 1'b1;
            end
        end
    end

    assign src_ret[LONGP_SRC_LSU]  = retire & sel_lsu;
    assign src_ret[LONGP_SRC_NICE] = retire & sel_nice;
    assign oitf_ret_ena = retire;

    // Payloads are forced to zero whenever the matching valid is low.
    assign wbck_o_valid = any_sel & ~sel_ent.err & oitf_ret_rdwen;
    assign wbck_o_wdat  = wbck_o_valid ? sel_ent.wdat   : '0;
    assign wbck_o_rdidx = wbck_o_valid ? oitf_ret_rdidx : 5'd0;
    assign wbck_o_rdfpu = wbck_o_valid & oitf_ret_rdfpu;

    assign excp_o_valid   = any_sel & sel_ent.err;
    assign excp_o_pc      = excp_o_valid ? oitf_ret_pc     : '0;
    assign excp_o_badaddr = excp_o_valid ? sel_ent.badaddr : '0;
    assign excp_o_insterr = excp_o_valid & sel_nice;
    assign excp_o_buserr  = excp_o_valid & sel_ent.buserr;
    assign excp_o_ld      = excp_o_valid & sel_ent.ld;
    assign excp_o_st      = excp_o_valid & sel_ent.st;

    // Watchdog counts cycles where the OITF has a head that is not retiring.
    always_comb begin
        wdg_cnt_next = wdg_cnt_reg;
        if (oitf_empty | retire) begin
            wdg_cnt_next = '0;
        end else if (wdg_cnt_reg != WDG_MAX) begin
            wdg_cnt_next = wdg_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdg_cnt_reg <= '0;
        end else begin
            wdg_cnt_reg <= wdg_cnt_next;
        end
    end

    assign stall_timeout = (wdg_cnt_reg == WDG_MAX);

endmodule

// File: tb/tb_e203_exu_longp_ret_sched.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_longp_ret_sched
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model of the two held results and the stall counter predicts every
//   output each cycle.
// ---------------------------------------------------------------------------
module tb_e203_exu_longp_ret_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        lsu_i_valid, lsu_i_ready;
    logic [31:0] lsu_i_wdat, lsu_i_badaddr;
    logic [0:0]  lsu_i_itag;
    logic        lsu_i_err, lsu_i_buserr, lsu_i_ld, lsu_i_st;
    logic        nice_i_valid, nice_i_ready;
    logic [31:0] nice_i_wdat;
    logic [0:0]  nice_i_itag;
    logic        nice_i_err;
    logic        oitf_empty;
    logic [0:0]  oitf_ret_ptr;
    logic [4:0]  oitf_ret_rdidx;
    logic        oitf_ret_rdwen, oitf_ret_rdfpu;
    logic [31:0] oitf_ret_pc;
    logic        oitf_ret_ena;
    logic        wbck_o_valid, wbck_o_ready;
    logic [31:0] wbck_o_wdat;
    logic [4:0]  wbck_o_rdidx;
    logic        wbck_o_rdfpu;
    logic        excp_o_valid, excp_o_ready;
    logic [31:0] excp_o_pc, excp_o_badaddr;
    logic        excp_o_insterr, excp_o_buserr, excp_o_ld, excp_o_st;
    logic        stall_timeout;

    e203_exu_longp_ret_sched #(.XLEN(32), .ITAG_W(1), .WDG_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_i_valid    (lsu_i_valid),
        .lsu_i_ready    (lsu_i_ready),
        .lsu_i_wdat     (lsu_i_wdat),
        .lsu_i_itag     (lsu_i_itag),
        .lsu_i_err      (lsu_i_err),
        .lsu_i_buserr   (lsu_i_buserr),
        .lsu_i_badaddr  (lsu_i_badaddr),
        .lsu_i_ld       (lsu_i_ld),
        .lsu_i_st       (lsu_i_st),
        .nice_i_valid   (nice_i_valid),
        .nice_i_ready   (nice_i_ready),
        .nice_i_wdat    (nice_i_wdat),
        .nice_i_itag    (nice_i_itag),
        .nice_i_err     (nice_i_err),
        .oitf_empty     (oitf_empty),
        .oitf_ret_ptr   (oitf_ret_ptr),
        .oitf_ret_rdidx (oitf_ret_rdidx),
        .oitf_ret_rdwen (oitf_ret_rdwen),
        .oitf_ret_rdfpu (oitf_ret_rdfpu),
        .oitf_ret_pc    (oitf_ret_pc),
        .oitf_ret_ena   (oitf_ret_ena),
        .wbck_o_valid   (wbck_o_valid),
        .wbck_o_ready   (wbck_o_ready),
        .wbck_o_wdat    (wbck_o_wdat),
        .wbck_o_rdidx   (wbck_o_rdidx),
        .wbck_o_rdfpu   (wbck_o_rdfpu),
        .excp_o_valid   (excp_o_valid),
        .excp_o_ready   (excp_o_ready),
        .excp_o_pc      (excp_o_pc),
        .excp_o_badaddr (excp_o_badaddr),
        .excp_o_insterr (excp_o_insterr),
        .excp_o_buserr  (excp_o_buserr),
        .excp_o_ld      (excp_o_ld),
        .excp_o_st      (excp_o_st),
        .stall_timeout  (stall_timeout)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: what each source is currently holding, and how many
    // consecutive cycles the OITF head has been waiting.
    typedef struct {
        bit          has;
        logic [31:0] wdat;
        logic [31:0] badaddr;
        bit          itag;
        bit          err;
        bit          buserr;
        bit          ld;
        bit          st;
    } ment_t;

    ment_t m_lsu;
    ment_t m_nice;
    int    m_wdg;

    task automatic set_idle();
        rst = 1'b0;
        lsu_i_valid = 1'b0; lsu_i_wdat = '0; lsu_i_itag = '0; lsu_i_err = 1'b0;
        lsu_i_buserr = 1'b0; lsu_i_badaddr = '0; lsu_i_ld = 1'b0; lsu_i_st = 1'b0;
        nice_i_valid = 1'b0; nice_i_wdat = '0; nice_i_itag = '0; nice_i_err = 1'b0;
        oitf_empty = 1'b1; oitf_ret_ptr = '0; oitf_ret_rdidx = '0;
        oitf_ret_rdwen = 1'b0; oitf_ret_rdfpu = 1'b0; oitf_ret_pc = '0;
        wbck_o_ready = 1'b1; excp_o_ready = 1'b1;
    endtask

    // Inputs are already applied (just after a falling edge). Predict and
    // compare all outputs, let the rising edge happen, advance the model,
    // and return at the next falling edge.
    task automatic cycle();
        ment_t e;
        bit sl, sn, any, wb, ex, ret, rdy_l, rdy_n;
        #1;
        sl  = !rst && m_lsu.has && !oitf_empty && (m_lsu.itag == oitf_ret_ptr[0]);
        sn  = !rst && !sl && m_nice.has && !oitf_empty && (m_nice.itag == oitf_ret_ptr[0]);
        any = sl || sn;
        e   = sl ? m_lsu : m_nice;
        ex  = any && e.err;
        wb  = any && !e.err && oitf_ret_rdwen;
        if (!any)      ret = 1'b0;
        else if (ex)   ret = excp_o_ready;
        else if (wb)   ret = wbck_o_ready;
        else           ret = 1'b1;
        rdy_l = !m_lsu.has  || (ret && sl);
        rdy_n = !m_nice.has || (ret && sn);

        chk("lsu_i_ready",   lsu_i_ready,   rdy_l);
        chk("nice_i_ready",  nice_i_ready,  rdy_n);
        chk("oitf_ret_ena",  oitf_ret_ena,  ret);
        chk("wbck_o_valid",  wbck_o_valid,  wb);
        chk("excp_o_valid",  excp_o_valid,  ex);
        chk("stall_timeout", stall_timeout, m_wdg == 255);
        if (wb) begin
            chk("wbck_o_wdat",  wbck_o_wdat,  e.wdat);
            chk("wbck_o_rdidx", wbck_o_rdidx, oitf_ret_rdidx);
            chk("wbck_o_rdfpu", wbck_o_rdfpu, oitf_ret_rdfpu);
        end
        if (ex) begin
            chk("excp_o_pc",      excp_o_pc,      oitf_ret_pc);
            chk("excp_o_badaddr", excp_o_badaddr, sn ? 32'd0 : e.badaddr);
            chk("excp_o_insterr", excp_o_insterr, sn);
            chk("excp_o_buserr",  excp_o_buserr,  sl && e.buserr);
            chk("excp_o_ld",      excp_o_ld,      sl && e.ld);
            chk("excp_o_st",      excp_o_st,      sl && e.st);
        end

        @(posedge clk);
        if (rst) begin
            m_lsu.has = 1'b0;
            m_nice.has = 1'b0;
            m_wdg = 0;
        end else begin
            if (ret && sl) m_lsu.has = 1'b0;
            if (ret && sn) m_nice.has = 1'b0;
            if (lsu_i_valid && rdy_l) begin
                m_lsu.has = 1'b1; m_lsu.wdat = lsu_i_wdat; m_lsu.badaddr = lsu_i_badaddr;
                m_lsu.itag = lsu_i_itag[0]; m_lsu.err = lsu_i_err; m_lsu.buserr = lsu_i_buserr;
                m_lsu.ld = lsu_i_ld; m_lsu.st = lsu_i_st;
            end
            if (nice_i_valid && rdy_n) begin
                m_nice.has = 1'b1; m_nice.wdat = nice_i_wdat; m_nice.badaddr = '0;
                m_nice.itag = nice_i_itag[0]; m_nice.err = nice_i_err; m_nice.buserr = 1'b0;
                m_nice.ld = 1'b0; m_nice.st = 1'b0;
            end
            if (oitf_empty || ret) m_wdg = 0;
            else if (m_wdg < 255)  m_wdg++;
        end
        @(negedge clk);
    endtask

    initial begin
        m_lsu.has = 1'b0;
        m_nice.has = 1'b0;
        m_wdg = 0;
        set_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state: everything idle, both sources ready.
        #1;
        chk("rst_lsu_ready",  lsu_i_ready,  1);
        chk("rst_nice_ready", nice_i_ready, 1);
        chk("rst_wbck_valid", wbck_o_valid, 0);
        chk("rst_excp_valid", excp_o_valid, 0);
        chk("rst_ret_ena",    oitf_ret_ena, 0);
        chk("rst_stall",      stall_timeout, 0);
        chk("rst_wbck_wdat",  wbck_o_wdat,  0);
        chk("rst_excp_pc",    excp_o_pc,    0);
        cycle();

        // 1: simple LSU writeback, retires the cycle after acceptance.
        oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; oitf_ret_rdwen = 1'b1; oitf_ret_rdidx = 5'd5;
        oitf_ret_pc = 32'h0000_1000;
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_wdat = 32'hDEAD_BEEF;
        #1 chk("t1_no_same_cycle", oitf_ret_ena, 0);
        cycle();
        lsu_i_valid = 1'b0;
        #1;
        chk("t1_wbck_valid", wbck_o_valid, 1);
        chk("t1_rdidx",      wbck_o_rdidx, 5);
        chk("t1_wdat",       wbck_o_wdat,  32'hDEAD_BEEF);
        chk("t1_ret_ena",    oitf_ret_ena, 1);
        cycle();

        // 2: NICE (tag 1) arrives before LSU (tag 0); OITF order wins.
        nice_i_valid = 1'b1; nice_i_itag = 1'b1; nice_i_wdat = 32'h1234_5678;
        cycle();
        nice_i_valid = 1'b0;
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_wdat = 32'hA5A5_0001;
        #1 chk("t2_nice_waits", oitf_ret_ena, 0);
        cycle();
        lsu_i_valid = 1'b0;
        #1 chk("t2_lsu_first", wbck_o_wdat, 32'hA5A5_0001);
        cycle();
        oitf_ret_ptr = 1'b1; oitf_ret_rdidx = 5'd9;
        #1;
        chk("t2_nice_wdat",  wbck_o_wdat,  32'h1234_5678);
        chk("t2_nice_ready", nice_i_ready, 1);
        chk("t2_nice_ret",   oitf_ret_ena, 1);
        cycle();

        // 3: LSU bus-error load held on the exception port for 3 cycles.
        oitf_ret_ptr = 1'b0; oitf_ret_pc = 32'h8000_0040; excp_o_ready = 1'b0;
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_err = 1'b1; lsu_i_buserr = 1'b1;
        lsu_i_ld = 1'b1; lsu_i_badaddr = 32'h8000_1000;
        cycle();
        set_idle();
        oitf_empty = 1'b0; oitf_ret_ptr = 1'b0; oitf_ret_pc = 32'h8000_0040;
        oitf_ret_rdwen = 1'b1; excp_o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_excp_held",    excp_o_valid,   1);
            chk("t3_badaddr",      excp_o_badaddr, 32'h8000_1000);
            chk("t3_no_ret",       oitf_ret_ena,   0);
            cycle();
        end
        excp_o_ready = 1'b1;
        #1 chk("t3_ret_4th", oitf_ret_ena, 1);
        cycle();

        // 4: no destination register, no error: retire on selection.
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_wdat = 32'h0000_0077;
        cycle();
        lsu_i_valid = 1'b0; oitf_ret_rdwen = 1'b0; wbck_o_ready = 1'b0;
        #1;
        chk("t4_ret",        oitf_ret_ena, 1);
        chk("t4_wbck_valid", wbck_o_valid, 0);
        cycle();

        // 5: watchdog saturation and clear.
        set_idle();
        cycle();
        oitf_empty = 1'b0; oitf_ret_ptr = 1'b0;
        for (int i = 0; i < 255; i++) cycle();
        #1 chk("t5_timeout", stall_timeout, 1);
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0;
        cycle();
        lsu_i_valid = 1'b0;
        cycle();
        #1 chk("t5_cleared", stall_timeout, 0);
        cycle();

        // 6: reset with both buffers full discards them without a pop.
        set_idle();
        lsu_i_valid = 1'b1; lsu_i_itag = 1'b0; lsu_i_wdat = 32'h1111_1111;
        nice_i_valid = 1'b1; nice_i_itag = 1'b1; nice_i_wdat = 32'h2222_2222;
        cycle();
        lsu_i_valid = 1'b0; nice_i_valid = 1'b0;
        rst = 1'b1; oitf_empty = 1'b0; oitf_ret_rdwen = 1'b1;
        #1 chk("t6_rst_no_ret", oitf_ret_ena, 0);
        cycle();
        rst = 1'b0;
        #1;
        chk("t6_lsu_ready",  lsu_i_ready,  1);
        chk("t6_nice_ready", nice_i_ready, 1);
        chk("t6_wbck_valid", wbck_o_valid, 0);
        chk("t6_ret",        oitf_ret_ena, 0);
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 63) == 0);
            lsu_i_valid    = $urandom_range(0, 1);
            lsu_i_wdat     = $urandom;
            lsu_i_itag     = 1'($urandom_range(0, 1));
            lsu_i_err      = ($urandom_range(0, 3) == 0);
            lsu_i_buserr   = $urandom_range(0, 1);
            lsu_i_badaddr  = $urandom;
            lsu_i_ld       = $urandom_range(0, 1);
            lsu_i_st       = $urandom_range(0, 1);
            nice_i_valid   = $urandom_range(0, 1);
            nice_i_wdat    = $urandom;
            nice_i_itag    = 1'($urandom_range(0, 1));
            nice_i_err     = ($urandom_range(0, 3) == 0);
            oitf_empty     = ($urandom_range(0, 7) == 0);
            oitf_ret_ptr   = 1'($urandom_range(0, 1));
            oitf_ret_rdidx = 5'($urandom_range(0, 31));
            oitf_ret_rdwen = ($urandom_range(0, 3) != 0);
            oitf_ret_rdfpu = $urandom_range(0, 1);
            oitf_ret_pc    = $urandom;
            wbck_o_ready   = ($urandom_range(0, 9) < 7);
            excp_o_ready   = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
